full_adder_4bit: RTL and testbench

//   Registered WIDTH-bit binary adder with carry-in and carry-out.

---
 rtl/full_adder_4bit.sv | 57 +++++
 tb/tb_full_adder_4bit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/full_adder_4bit.sv
// rtl/full_adder_4bit.sv - registered WIDTH-bit ripple-carry adder with carry in/out
// Optional FULL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module full_adder_4bit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_next;

   assign carry[0] = cin;

   // One full-adder cell per bit; carry ripples from LSB to MSB.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign sum_next[i]  = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum  <= sum_next;
            cout <= carry[WIDTH];
         end
      end
   end

`ifdef FULL_ADDER_OVF_EN
   // Signed overflow: carry into the sign bit differs from carry out of it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (in_valid) begin
         ovf <= carry[WIDTH] ^ carry[WIDTH-1];
      end
   end
`endif

endmodule

// File: tb/tb_full_adder_4bit.sv
// tb/tb_full_adder_4bit.sv - self-checking bench for full_adder_4bit
module tb_full_adder_4bit;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] a, b;
   logic         cin;
   logic [W-1:0] sum;
   logic         cout;
   logic         out_valid;
`ifdef FULL_ADDER_OVF_EN
   logic         ovf;
`endif

   int total = 0;
   int bad   = 0;

   // Reference state: what the outputs should show after the latest edge.
   int m_sum, m_cout, m_vld, m_ovf;

   full_adder_4bit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a(a), .b(b), .cin(cin),
      .sum(sum), .cout(cout), .out_valid(out_valid)
`ifdef FULL_ADDER_OVF_EN
      , .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input int av, input int bv, input int cv);
      in_valid = v;
      a = W'(av);
      b = W'(bv);
      cin = cv[0];
   endtask

   // Advance one edge and update the reference from plain integer arithmetic.
   task automatic tick();
      int total_sum, sa, sb, ss;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         m_sum = 0; m_cout = 0; m_vld = 0; m_ovf = 0;
      end else begin
         m_vld = in_valid;
         if (in_valid) begin
            total_sum = int'(a) + int'(b) + int'(cin);
            m_sum  = total_sum % (1 << W);
            m_cout = total_sum / (1 << W);
            sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
            sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
            ss = sa + sb + int'(cin);
            m_ovf = (ss > (1 << (W-1)) - 1 || ss < -(1 << (W-1))) ? 1 : 0;
         end
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_sum"}, 8'(sum), 8'(m_sum));
      chk({tag, "_cout"}, 8'(cout), 8'(m_cout));
      chk({tag, "_vld"}, 8'(out_valid), 8'(m_vld));
`ifdef FULL_ADDER_OVF_EN
      chk({tag, "_ovf"}, 8'(ovf), 8'(m_ovf));
`endif
   endtask

   task automatic chk_const(input string tag, input int s, input int c, input int o);
      chk({tag, "_sum"}, 8'(sum), 8'(s));
      chk({tag, "_cout"}, 8'(cout), 8'(c));
      chk({tag, "_vld"}, 8'(out_valid), 8'd1);
`ifdef FULL_ADDER_OVF_EN
      chk({tag, "_ovf"}, 8'(ovf), 8'(o));
`else
      if (o > 1) $display("note: unexpected ovf constant");
`endif
   endtask

   initial begin
      // Reset with in_valid high must still clear everything.
      rst_n = 1'b0;
      drive(1'b1, 4'hF, 4'hF, 1);
      tick();
      tick();
      chk("rst_sum", 8'(sum), 8'd0);
      chk("rst_cout", 8'(cout), 8'd0);
      chk("rst_vld", 8'(out_valid), 8'd0);
`ifdef FULL_ADDER_OVF_EN
      chk("rst_ovf", 8'(ovf), 8'd0);
`endif
      rst_n = 1'b1;

      drive(1'b1, 4'b0101, 4'b0111, 1); tick(); chk_const("c2", 4'b1101, 0, 1);
      drive(1'b1, 4'b1010, 4'b0001, 0); tick(); chk_const("c3", 4'b1011, 0, 0);
      drive(1'b1, 4'b0011, 4'b0101, 1); tick(); chk_const("c4", 4'b1001, 0, 1);
      drive(1'b1, 4'b1111, 4'b0001, 0); tick(); chk_const("c5a", 4'b0000, 1, 0);
      drive(1'b1, 4'b1111, 4'b1111, 1); tick(); chk_const("c5b", 4'b1111, 1, 0);
      drive(1'b1, 0, 0, 0);             tick(); chk_const("zero", 0, 0, 0);

      // Back-to-back, then idle: result holds while out_valid drops.
      drive(1'b1, 4'b0101, 4'b0111, 1); tick(); chk_const("b2b0", 4'b1101, 0, 1);
      drive(1'b1, 4'b1010, 4'b0001, 0); tick(); chk_const("b2b1", 4'b1011, 0, 0);
      drive(1'b1, 4'b0011, 4'b0101, 1); tick(); chk_const("b2b2", 4'b1001, 0, 1);
      drive(1'b0, 4'b1111, 4'b1111, 1); tick();
      chk("hold_sum", 8'(sum), 8'b1001);
      chk("hold_vld", 8'(out_valid), 8'd0);
      tick();
      chk_model("hold2");

      // Reset mid-stream discards the in-flight operation.
      drive(1'b1, 4'hE, 4'h3, 1);
      rst_n = 1'b0; tick(); chk_model("midrst");
      rst_n = 1'b1;

      // Exhaustive sweep.
      for (int i = 0; i < 512; i++) begin
         drive(1'b1, i[3:0], i[7:4], i[8]);
         tick();
         chk_model("sweep");
      end

      // Random mix of valid/idle cycles and occasional resets.
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom);
         rst_n = ($urandom_range(0, 29) != 0);
         tick();
         chk_model("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
